quad_velocity_meter: RTL and testbench
======================================

Name: quad_velocity_meter

Overview:
- Produces the process-value (pv) stream for the PID controller, i.e. the producer end of the PID's pv input.
- Decodes a 2-channel quadrature motor encoder in x4 mode and counts signed steps over a fixed sample window.
- At each window end, emits the step magnitude and direction with a one-cycle valid strobe, for the PID to latch as pv.

Parameters:
- SAMPLE_CYCLES, 12000: window length in i_clk cycles (1 ms at 12 MHz); must be >= 2.
- PV_W, 16: width of o_pv; matches the PID pv port.
- SYNC_STAGES, 2: flip-flops in the input synchronizer per encoder channel; must be >= 2.

Ports:
- i_clk, input, 1: system clock; all logic is on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_en, input, 1: measurement enable.
- i_a, input, 1: encoder channel A, asynchronous to i_clk.
- i_b, input, 1: encoder channel B, asynchronous to i_clk.
- o_pv, output, PV_W: step magnitude for the last window, saturated.
- o_dir, output, 1: direction for the last window; 0 = forward/zero, 1 = reverse.
- o_valid, output, 1: one-cycle strobe; o_pv and o_dir are updated on this cycle.
- o_err, output, 1: one-cycle pulse on an illegal quadrature transition.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous and active-high (i_rst). While i_rst is high, the block clears:
  - o_pv = 0, o_dir = 0, o_valid = 0, o_err = 0;
  - synchronizer and previous-state registers = 00;
  - window counter = 0 and accumulator = 0.
- Synchronizer: i_a and i_b each pass through SYNC_STAGES flops. A previous-state register holds the last synchronized {A,B}.
- Decode, comparing previous {A,B} with current {A,B}:
  - Forward = 00->01->11->10->00: step +1.
  - Reverse = the opposite order: step -1.
  - No change: step 0.
  - Both bits changed (00<->11 or 01<->10): illegal. o_err pulses high for 1 cycle, step 0, previous state still updates.
- Latency: a pin transition reaches the accumulator SYNC_STAGES+1 cycles later (3 by default).
- Accumulator: signed, PV_W+1 bits, saturating at +(2^PV_W - 1) and -(2^PV_W - 1). It never wraps.
- Window counter:
  - Counts 0..SAMPLE_CYCLES-1 while i_en = 1.
  - On the terminal-count cycle, it returns to 0 and the output registers load:
    - o_pv <= |acc + step|, saturated to 2^PV_W - 1;
    - o_dir <= 1 if (acc + step) < 0, else 0;
    - o_valid <= 1 for that single cycle.
    - acc <= 0.
  - A step decoded on the terminal cycle belongs to the closing window.
  - A step on the following cycle belongs to the new window.
- First o_valid: exactly SAMPLE_CYCLES cycles after i_en rises, measured from the first enabled clock edge.
- i_en = 0:
  - Window counter and accumulator are held at 0; o_valid stays 0.
  - o_pv and o_dir keep their last values.
  - The synchronizer, previous-state register and o_err keep running, so no false step appears when i_en is re-enabled.
- i_en falling mid-window: the partial window is discarded; no o_valid is issued.
- Reset mid-window: all state clears immediately; no o_valid is issued for the aborted window.
- o_pv and o_dir are stable between strobes. The PID may sample them on o_valid or at any later cycle.

Decomposition:
- Shared package holds:
  - PV_W = 16;
  - quadrature state encodings (Q00 = 2'b00, Q01 = 2'b01, Q11 = 2'b11, Q10 = 2'b10);
  - step encoding (STEP_NONE, STEP_FWD, STEP_REV).
- One sub-module, quad_decoder: synchronizer plus previous-state register plus transition decode. Its outputs are o_step_valid, o_step_dir and o_err. The top level holds the window counter, accumulator, saturation and output registers.

Test Plan (SAMPLE_CYCLES = 1000 unless noted):
- Forward count: after reset, i_en = 1; 30 forward steps, one every 20 cycles -> single o_valid at cycle 1000 with o_pv = 30, o_dir = 0; next window with no steps -> o_pv = 0, o_dir = 0.
- Reverse count: 45 reverse steps within one window -> o_pv = 45, o_dir = 1.
- Mixed and boundary: 10 forward, then 4 reverse, then 1 forward step timed to decode exactly on the terminal cycle -> o_pv = 7, o_dir = 0; 1 forward step decoded on the cycle after the terminal cycle -> counted in the next window, o_pv = 1.
- Illegal transition: drive A and B from 00 to 11 in the same cycle -> o_err high for exactly 1 cycle, 3 cycles later; window result unaffected, o_pv = 0.
- Saturation: SAMPLE_CYCLES = 300000, one forward step every 4 cycles -> o_pv = 16'hFFFF, o_dir = 0, with no wrap.
- Reset/enable: assert i_rst at cycle 500 of a window containing 20 steps -> all outputs read 0 at once, no o_valid; then drop i_en for 2000 cycles while toggling the encoder -> no o_valid; re-enable i_en -> first o_valid exactly 1000 cycles later, counting only post-enable steps.

Source files
------------

// File: rtl/quad_velocity_meter_pkg.sv
// Shared types for the quadrature velocity meter: pv width, quadrature
// state encodings, step encoding and the transition-to-step decode.
package quad_velocity_meter_pkg;

  localparam int PV_W = 16;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_REV  = 2'b10
  } step_t;

  // Both-bits-changed transitions fall to STEP_NONE; the decoder flags them separately.
  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: s = STEP_FWD;
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: s = STEP_REV;
      default: s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Encoder front end: per-channel synchronizer, previous-state register and
// combinational x4 transition decode.
module quad_decoder
  import quad_velocity_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  output logic o_step_valid,
  output logic o_step_dir,
  output logic o_err
);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             cur;
  step_t                  step;

  always_comb begin
    sync_a_d     = {sync_a_q[SYNC_STAGES-2:0], i_a};
    sync_b_d     = {sync_b_q[SYNC_STAGES-2:0], i_b};
    cur          = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    prev_d       = cur;
    step         = quad_step(prev_q, cur);
    o_step_valid = (step != STEP_NONE);
    o_step_dir   = (step == STEP_REV);
    o_err        = ((prev_q ^ cur) == 2'b11);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_q   <= Q00;
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      prev_q   <= prev_d;
    end
  end

endmodule

// File: rtl/quad_velocity_meter.sv
// Quadrature velocity meter: counts signed encoder steps over a fixed window
// and presents saturated magnitude plus direction with a one-cycle strobe.
module quad_velocity_meter #(
  parameter int SAMPLE_CYCLES = 12000,
  parameter int PV_W          = quad_velocity_meter_pkg::PV_W,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_a,
  input  logic            i_b,
  output logic [PV_W-1:0] o_pv,
  output logic            o_dir,
  output logic            o_valid,
  output logic            o_err
);
  import quad_velocity_meter_pkg::*;

  localparam int CNT_W = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int ACC_W = PV_W + 1;
  localparam int SUM_W = PV_W + 2;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = {2'b00, {PV_W{1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN  = -SAT_MAX;

  logic                    step_valid, step_dir, dec_err;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PV_W-1:0]         pv_q, pv_d;
  logic                    dir_q, dir_d, valid_q, valid_d, err_q, err_d;
  logic signed [SUM_W-1:0] step_ext, sum, sum_sat;
  logic signed [ACC_W-1:0] acc_next, acc_abs;

  quad_decoder #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dec (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_step_valid(step_valid),
    .o_step_dir  (step_dir),
    .o_err       (dec_err)
  );

  // acc + step is saturated before it is either stored or published
  always_comb begin
    step_ext = '0;
    if (step_valid) step_ext = step_dir ? {SUM_W{1'b1}} : SUM_W'(1);
    sum     = {acc_q[ACC_W-1], acc_q} + step_ext;
    sum_sat = sum;
    if (sum > SAT_MAX)      sum_sat = SAT_MAX;
    else if (sum < SAT_MIN) sum_sat = SAT_MIN;
    acc_next = sum_sat[ACC_W-1:0];
    acc_abs  = (acc_next < 0) ? -acc_next : acc_next;
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pv_d    = pv_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    err_d   = dec_err;
    if (!i_en) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      acc_d   = '0;
      pv_d    = acc_abs[PV_W-1:0];
      dir_d   = (acc_next < 0);
      valid_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = acc_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      pv_q    <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_pv    = pv_q;
  assign o_dir   = dir_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_quad_velocity_meter.sv
// Directed bench for quad_velocity_meter: window counting, direction,
// terminal-cycle boundary, illegal transitions, reset/enable and saturation.
module tb_quad_velocity_meter;

  localparam int SC   = 1000;
  localparam int SC_S = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic [1:0] qs = 2'b00;

  logic [15:0] pv;
  logic        dir, valid, err;
  logic [7:0]  pv_s;
  logic        dir_s, valid_s, err_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quad_velocity_meter #(.SAMPLE_CYCLES(SC), .PV_W(16), .SYNC_STAGES(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .i_b(b),
    .o_pv(pv), .o_dir(dir), .o_valid(valid), .o_err(err)
  );

  quad_velocity_meter #(.SAMPLE_CYCLES(SC_S), .PV_W(8), .SYNC_STAGES(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .i_b(b),
    .o_pv(pv_s), .o_dir(dir_s), .o_valid(valid_s), .o_err(err_s)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input bit fwd);
    if (fwd) begin
      case (qs)
        2'b00:   qs = 2'b01;
        2'b01:   qs = 2'b11;
        2'b11:   qs = 2'b10;
        default: qs = 2'b00;
      endcase
    end else begin
      case (qs)
        2'b00:   qs = 2'b10;
        2'b10:   qs = 2'b11;
        2'b11:   qs = 2'b01;
        default: qs = 2'b00;
      endcase
    end
    {a, b} = qs;
  endtask

  task automatic do_reset;
    en = 1'b0;
    qs = 2'b00;
    {a, b} = qs;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (pv !== 16'd0) begin failures++; $display("FAIL reset_pv got=%0d exp=0", pv); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", dir); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if ({pv_s, dir_s, valid_s, err_s} !== 11'd0) begin failures++; $display("FAIL reset_sat got=%h exp=0", {pv_s, dir_s, valid_s, err_s}); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_forward;
    int early;
    do_reset();
    en = 1'b1;
    early = 0;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i < SC && valid) early++;
      if (i % 20 == 1 && i <= 581) step(1'b1);
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL fwd_early_valid got=%0d exp=0", early); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL fwd_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd30) begin failures++; $display("FAIL fwd_pv got=%0d exp=30", pv); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL fwd_dir got=%0b exp=0", dir); end
    early = 0;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i < SC && valid) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL fwd_strobe_width extra_valid=%0d exp=0", early); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL idle_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd0) begin failures++; $display("FAIL idle_pv got=%0d exp=0", pv); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL idle_dir got=%0b exp=0", dir); end
  endtask

  task automatic test_reverse;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 441) step(1'b0);
    end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rev_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd45) begin failures++; $display("FAIL rev_pv got=%0d exp=45", pv); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL rev_dir got=%0b exp=1", dir); end
  endtask

  task automatic test_boundary;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 91) step(1'b1);
      if (i % 10 == 1 && i >= 201 && i <= 231) step(1'b0);
      if (i == 997) step(1'b1);
      if (i == 998) step(1'b1);
    end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bnd_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd7) begin failures++; $display("FAIL bnd_terminal_pv got=%0d exp=7", pv); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL bnd_dir got=%0b exp=0", dir); end
    tick(SC);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bnd_next_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd1) begin failures++; $display("FAIL bnd_next_pv got=%0d exp=1", pv); end
  endtask

  task automatic test_illegal;
    int errs;
    do_reset();
    en = 1'b1;
    errs = 0;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (err) errs++;
      if (i == 103) begin
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%0b exp=0", err); end
      end
      if (i == 104) begin
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%0b exp=1", err); end
      end
      if (i == 105) begin
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_width got=%0b exp=0", err); end
      end
      if (i == 101) begin
        qs = 2'b11;
        {a, b} = qs;
      end
    end
    checks++; if (errs !== 1) begin failures++; $display("FAIL err_count got=%0d exp=1", errs); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL err_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd0) begin failures++; $display("FAIL err_pv got=%0d exp=0", pv); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL err_dir got=%0b exp=0", dir); end
  endtask

  task automatic test_reset_enable;
    int vcnt;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 191) step(1'b1);
    end
    checks++; if (pv !== 16'd20) begin failures++; $display("FAIL re_pre_pv got=%0d exp=20", pv); end
    for (int i = 1; i <= 500; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 191) step(1'b1);
    end
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++; if (pv !== 16'd0) begin failures++; $display("FAIL re_async_pv got=%0d exp=0", pv); end
    checks++; if ({dir, valid, err} !== 3'b000) begin failures++; $display("FAIL re_async_flags got=%b exp=000", {dir, valid, err}); end
    tick(3);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick(1);
      if (valid) vcnt++;
      if (i % 10 == 1 && i <= 1900) step(1'b1);
    end
    checks++; if (vcnt !== 0) begin failures++; $display("FAIL re_disabled_valid got=%0d exp=0", vcnt); end
    en = 1'b1;
    vcnt = 0;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i < SC && valid) vcnt++;
      if (i % 10 == 1 && i <= 41) step(1'b1);
    end
    checks++; if (vcnt !== 0) begin failures++; $display("FAIL re_early_valid got=%0d exp=0", vcnt); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL re_first_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd5) begin failures++; $display("FAIL re_pv got=%0d exp=5", pv); end
    for (int i = 1; i <= 400; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 21) step(1'b0);
    end
    en = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 1500; i++) begin
      tick(1);
      if (valid) vcnt++;
    end
    checks++; if (vcnt !== 0) begin failures++; $display("FAIL drop_valid got=%0d exp=0", vcnt); end
    checks++; if (pv !== 16'd5 || dir !== 1'b0) begin failures++; $display("FAIL hold_pv got=%0d/%0b exp=5/0", pv, dir); end
    en = 1'b1;
    for (int i = 1; i <= SC; i++) begin
      tick(1);
      if (i % 10 == 1 && i <= 11) step(1'b1);
    end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL discard_valid got=%0b exp=1", valid); end
    checks++; if (pv !== 16'd2 || dir !== 1'b0) begin failures++; $display("FAIL discard_pv got=%0d/%0b exp=2/0", pv, dir); end
  endtask

  task automatic test_saturation;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 2 * SC_S; i++) begin
      tick(1);
      if (i == SC) begin
        checks++; if (valid !== 1'b1 || pv !== 16'd250) begin failures++; $display("FAIL sat_main_pv got=%0d/%0b exp=250/1", pv, valid); end
      end
      if (i == SC_S) begin
        checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL sat_fwd_valid got=%0b exp=1", valid_s); end
        checks++; if (pv_s !== 8'hFF || dir_s !== 1'b0) begin failures++; $display("FAIL sat_fwd_pv got=%h/%0b exp=ff/0", pv_s, dir_s); end
      end
      if (i % 4 == 1) step(i <= SC_S);
    end
    checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL sat_rev_valid got=%0b exp=1", valid_s); end
    checks++; if (pv_s !== 8'hFF || dir_s !== 1'b1) begin failures++; $display("FAIL sat_rev_pv got=%h/%0b exp=ff/1", pv_s, dir_s); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_boundary();
    test_illegal();
    test_reset_enable();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
